// File: rtl/return_stack.sv
// -----------------------------------------------------------------------------
// return_stack
//   Circular hardware call/return stack for the iCEPIC core. CALL pushes the
//   return address, RETURN/RETLW/RETFIE pops it. The current top entry is
//   always visible on stack_addr_out so the PC can load it on the same edge
//   that retires the pop. Pushing onto a full stack silently overwrites the
//   oldest entry. Sticky overflow/underflow flags are provided for debug.
//
// Ports
//   clk_in          in   1          single clock, rising edge
//   reset_in        in   1          synchronous active-high reset, wins over push/pop
//   push_in         in   1          push push_addr_in this cycle (CALL)
//   pop_in          in   1          pop the top entry this cycle (RETURN)
//   push_addr_in    in   ADDR_W     return address to store
//   stack_addr_out  out  ADDR_W     current top entry, mem[sp-1]
//   depth_out       out  PTR_W+1    valid entries 0..DEPTH, saturating
//   overflow_out    out  1          sticky: push seen while full
//   underflow_out   out  1          sticky: pop seen while empty
// -----------------------------------------------------------------------------
module return_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 12
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic                     push_in,
  input  logic                     pop_in,
  input  logic [ADDR_W-1:0]        push_addr_in,
  output logic [ADDR_W-1:0]        stack_addr_out,
  output logic [$clog2(DEPTH):0]   depth_out,
  output logic                     overflow_out,
  output logic                     underflow_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_C  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] EMPTY_C = '0;
  localparam logic [PTR_W-1:0] ONE_P = PTR_W'(1);
  localparam logic [PTR_W:0]   ONE_D = (PTR_W + 1)'(1);

  logic [ADDR_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  sp_r;
  logic [PTR_W:0]    depth_r;
  logic              overflow_r;
  logic              underflow_r;

  logic [PTR_W-1:0]  top_idx_s;
  logic [PTR_W-1:0]  sp_nxt_s;
  logic [PTR_W:0]    depth_nxt_s;
  logic              overflow_nxt_s;
  logic              underflow_nxt_s;
  logic              wr_en_s;
  logic [PTR_W-1:0]  wr_idx_s;

  // sp points at the next free slot, so the top lives one below (mod DEPTH).
  assign top_idx_s      = sp_r - ONE_P;
  assign stack_addr_out = mem_r[top_idx_s];
  assign depth_out      = depth_r;
  assign overflow_out   = overflow_r;
  assign underflow_out  = underflow_r;

  // Next-state decode for pointer, depth, flags and the storage write port.
  always_comb begin
    sp_nxt_s        = sp_r;
    depth_nxt_s     = depth_r;
    overflow_nxt_s  = overflow_r;
    underflow_nxt_s = underflow_r;
    wr_en_s         = 1'b0;
    wr_idx_s        = sp_r;
    case ({push_in, pop_in})
      2'b11: begin
        // Replace top in place: pointer, depth and flags untouched, even when
        // empty (then the slot below sp is rewritten but stays outside depth).
        wr_en_s  = 1'b1;
        wr_idx_s = top_idx_s;
      end
      2'b10: begin
        wr_en_s  = 1'b1;
        wr_idx_s = sp_r;
        sp_nxt_s = sp_r + ONE_P;
        if (depth_r == FULL_C) begin
          // Pointer wrap overwrites the oldest entry; depth stays saturated.
          overflow_nxt_s = 1'b1;
        end else begin
          depth_nxt_s = depth_r + ONE_D;
        end
      end
      2'b01: begin
        // sp wraps even on an empty pop so the pointer stays circular.
        sp_nxt_s = sp_r - ONE_P;
        if (depth_r == EMPTY_C) begin
          underflow_nxt_s = 1'b1;
        end else begin
          depth_nxt_s = depth_r - ONE_D;
        end
      end
      default: begin
        sp_nxt_s = sp_r;
      end
    endcase
  end

  // Control state registers: pointer, depth and sticky flags.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sp_r        <= '0;
      depth_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      sp_r        <= sp_nxt_s;
      depth_r     <= depth_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Entry storage: cleared on reset so stack_addr_out reads zero afterwards.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_idx_s] <= push_addr_in;
    end
  end

endmodule

// File: tb/tb_return_stack.sv
// -----------------------------------------------------------------------------
// tb_return_stack
//   Self-checking bench for return_stack (DEPTH=8, ADDR_W=12). Directed steps
//   with fixed expected values, then random push/pop/reset traffic compared to
//   an array-based reference model of the circular stack.
// -----------------------------------------------------------------------------
module tb_return_stack;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        push_in;
  logic        pop_in;
  logic [11:0] push_addr_in;
  logic [11:0] stack_addr_out;
  logic [3:0]  depth_out;
  logic        overflow_out;
  logic        underflow_out;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // reference model state
  logic [11:0] mem_m [8];
  int          sp_m;
  int          dep_m;
  bit          ovf_m;
  bit          unf_m;

  return_stack #(.DEPTH(8), .ADDR_W(12)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .push_in        (push_in),
    .pop_in         (pop_in),
    .push_addr_in   (push_addr_in),
    .stack_addr_out (stack_addr_out),
    .depth_out      (depth_out),
    .overflow_out   (overflow_out),
    .underflow_out  (underflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model of a circular stack: the top is the slot just below sp (mod 8).
  task automatic model_update(input bit psh, input bit pp, input logic [11:0] a, input bit rst);
    if (rst) begin
      for (int i = 0; i < 8; i++) mem_m[i] = 12'h000;
      sp_m = 0; dep_m = 0; ovf_m = 1'b0; unf_m = 1'b0;
    end else if (psh && pp) begin
      mem_m[(sp_m + 7) % 8] = a;
    end else if (psh) begin
      if (dep_m == 8) ovf_m = 1'b1;
      mem_m[sp_m] = a;
      sp_m  = (sp_m + 1) % 8;
      dep_m = (dep_m < 8) ? dep_m + 1 : 8;
    end else if (pp) begin
      if (dep_m == 0) unf_m = 1'b1;
      else dep_m = dep_m - 1;
      sp_m = (sp_m + 7) % 8;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"},   32'(stack_addr_out), 32'(mem_m[(sp_m + 7) % 8]));
    chk({tag, ".depth"}, 32'(depth_out),      32'(dep_m));
    chk({tag, ".ovf"},   32'(overflow_out),   32'(ovf_m));
    chk({tag, ".unf"},   32'(underflow_out),  32'(unf_m));
  endtask

  // Drive one cycle, then sample #1 after the edge and compare with the model.
  task automatic step(input bit psh, input bit pp, input logic [11:0] a, input bit rst, input string tag);
    push_in = psh; pop_in = pp; push_addr_in = a; reset_in = rst;
    @(posedge clk_in);
    #1;
    model_update(psh, pp, a, rst);
    check_model(tag);
    push_in = 1'b0; pop_in = 1'b0; reset_in = 1'b0;
  endtask

  logic [11:0] pop_exp [8];

  initial begin
    push_in = 1'b0; pop_in = 1'b0; push_addr_in = 12'h000; reset_in = 1'b1;
    for (int i = 0; i < 8; i++) mem_m[i] = 12'h000;
    sp_m = 0; dep_m = 0; ovf_m = 1'b0; unf_m = 1'b0;

    // 1. reset two cycles
    step(1'b0, 1'b0, 12'h000, 1'b1, "rst1");
    step(1'b0, 1'b0, 12'h000, 1'b1, "rst2");
    chk("rst_out",   32'(stack_addr_out), 32'h000);
    chk("rst_depth", 32'(depth_out),      32'd0);
    chk("rst_ovf",   32'(overflow_out),   32'd0);
    chk("rst_unf",   32'(underflow_out),  32'd0);

    // 2. push two, pop one
    step(1'b1, 1'b0, 12'h123, 1'b0, "t2_push1");
    step(1'b1, 1'b0, 12'h456, 1'b0, "t2_push2");
    chk("t2_out2",   32'(stack_addr_out), 32'h456);
    chk("t2_depth2", 32'(depth_out),      32'd2);
    step(1'b0, 1'b1, 12'h000, 1'b0, "t2_pop");
    chk("t2_outpop", 32'(stack_addr_out), 32'h123);
    chk("t2_depth1", 32'(depth_out),      32'd1);

    // 3. overflow by 9 pushes, drain, underflow
    step(1'b0, 1'b0, 12'h000, 1'b1, "t3_rst");
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 12'(i), 1'b0, "t3_push");
    chk("t3_ovf",   32'(overflow_out),   32'd1);
    chk("t3_depth", 32'(depth_out),      32'd8);
    chk("t3_out",   32'(stack_addr_out), 32'h009);
    pop_exp = '{12'h008, 12'h007, 12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h009};
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 12'h000, 1'b0, "t3_pop");
      chk($sformatf("t3_popout%0d", i), 32'(stack_addr_out), 32'(pop_exp[i]));
    end
    chk("t3_depth0", 32'(depth_out),     32'd0);
    chk("t3_unf0",   32'(underflow_out), 32'd0);
    step(1'b0, 1'b1, 12'h000, 1'b0, "t3_pop9");
    chk("t3_unf1",   32'(underflow_out), 32'd1);

    // 4. replace top with simultaneous push+pop
    step(1'b0, 1'b0, 12'h000, 1'b1, "t4_rst");
    step(1'b1, 1'b0, 12'h111, 1'b0, "t4_push1");
    step(1'b1, 1'b0, 12'h222, 1'b0, "t4_push2");
    step(1'b1, 1'b1, 12'h3AB, 1'b0, "t4_repl");
    chk("t4_out",   32'(stack_addr_out), 32'h3AB);
    chk("t4_depth", 32'(depth_out),      32'd2);
    chk("t4_ovf",   32'(overflow_out),   32'd0);
    chk("t4_unf",   32'(underflow_out),  32'd0);
    step(1'b0, 1'b1, 12'h000, 1'b0, "t4_pop");
    chk("t4_outpop", 32'(stack_addr_out), 32'h111);

    // 5. pop on empty, then push
    step(1'b0, 1'b0, 12'h000, 1'b1, "t5_rst");
    step(1'b0, 1'b1, 12'h000, 1'b0, "t5_pop");
    chk("t5_unf",   32'(underflow_out),  32'd1);
    chk("t5_depth", 32'(depth_out),      32'd0);
    chk("t5_out",   32'(stack_addr_out), 32'h000);
    step(1'b1, 1'b0, 12'h0AA, 1'b0, "t5_push");
    chk("t5_out2",   32'(stack_addr_out), 32'h0AA);
    chk("t5_depth1", 32'(depth_out),      32'd1);
    chk("t5_unf2",   32'(underflow_out),  32'd1);

    // 6. reset wins over push
    step(1'b0, 1'b0, 12'h000, 1'b1, "t6_rst");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 12'(12'h500 + i), 1'b0, "t6_push");
    step(1'b1, 1'b0, 12'h777, 1'b1, "t6_rstpush");
    chk("t6_depth", 32'(depth_out),      32'd0);
    chk("t6_out",   32'(stack_addr_out), 32'h000);
    chk("t6_ovf",   32'(overflow_out),   32'd0);
    chk("t6_unf",   32'(underflow_out),  32'd0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      bit psh, pp, rst;
      r   = int'($urandom_range(0, 99));
      rst = (r < 2);
      psh = (r >= 2  && r < 50) || (r >= 85);
      pp  = (r >= 45 && r < 85) || (r >= 93);
      step(psh, pp, 12'($urandom), rst, "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
